// File: rtl/mem_port_arbiter_if.sv
// Two-requester memory port bundle: requester handshakes,
// read returns and the single shared memory port.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] din0;
  logic              gnt0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] din1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  req0, we0, addr0, din0,
    input  req1, we1, addr1, din1,
    input  mem_dout,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output mem_en, mem_we, mem_addr, mem_din
  );

  modport master (
    output req0, we0, addr0, din0,
    output req1, we1, addr1, din1,
    output mem_dout,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  mem_en, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Burst-fair arbiter sharing one memory port between two
// requesters, with a tag pipeline steering read data back.
module mem_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1,
  parameter int BURST  = 4
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] BURST_C = 4'(BURST);

  logic              owner;
  logic [3:0]        run_cnt;
  logic              winner;
  logic              any_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_din;

  // tag stage k lines up with mem_dout at stage RD_LAT
  logic [RD_LAT:0]   tag_v;
  logic [RD_LAT:0]   tag_id;

  always_comb begin
    winner = owner;
    unique case (1'b1)
      (bus.req0 & ~bus.req1): winner = 1'b0;
      (bus.req1 & ~bus.req0): winner = 1'b1;
      (bus.req0 & bus.req1):
        winner = (run_cnt < BURST_C) ? owner : ~owner;
      default: winner = owner;
    endcase
  end

  assign bus.gnt0 = bus.req0 & ~winner & ~reset;
  assign bus.gnt1 = bus.req1 & winner & ~reset;
  assign any_gnt  = bus.gnt0 | bus.gnt1;

  assign sel_we   = winner ? bus.we1   : bus.we0;
  assign sel_addr = winner ? bus.addr1 : bus.addr0;
  assign sel_din  = winner ? bus.din1  : bus.din0;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner        <= 1'b1;
      run_cnt      <= BURST_C;
      bus.mem_en   <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_din  <= '0;
      tag_v        <= '0;
      tag_id       <= '0;
      bus.rvalid0  <= 1'b0;
      bus.rvalid1  <= 1'b0;
      bus.rdata0   <= '0;
      bus.rdata1   <= '0;
    end else begin
      if (any_gnt) begin
        if (winner == owner) begin
          if (run_cnt != BURST_C)
            run_cnt <= run_cnt + 4'd1;
        end else begin
          owner   <= winner;
          run_cnt <= 4'd1;
        end
      end else if (!bus.req0 && !bus.req1) begin
        // idle cycle hands the next tie to the non-owner
        run_cnt <= BURST_C;
      end

      bus.mem_en <= any_gnt;
      bus.mem_we <= any_gnt & sel_we;
      if (any_gnt) begin
        bus.mem_addr <= sel_addr;
        bus.mem_din  <= sel_din;
      end

      tag_v[0]  <= any_gnt & ~sel_we;
      tag_id[0] <= winner;
      for (int k = 1; k <= RD_LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end

      bus.rvalid0 <= tag_v[RD_LAT] & ~tag_id[RD_LAT];
      bus.rvalid1 <= tag_v[RD_LAT] & tag_id[RD_LAT];
      if (tag_v[RD_LAT] && !tag_id[RD_LAT])
        bus.rdata0 <= bus.mem_dout;
      if (tag_v[RD_LAT] && tag_id[RD_LAT])
        bus.rdata1 <= bus.mem_dout;
    end
  end

endmodule
